// File: rtl/osc_cfg_pkg.sv
// Shared constants, field/state encodings and the voice-slice helper for the oscillator bank
// configuration controller.
package osc_cfg_pkg;

  localparam int unsigned NUM_VOICES = 32;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BUS_W      = NUM_VOICES * WORD_W;
  localparam logic [WORD_W-1:0] RAMP_STEP = 16'd64;

  typedef enum logic [1:0] {
    FIELD_AMP    = 2'd0,
    FIELD_OFFSET = 2'd1,
    FIELD_PHASE  = 2'd2,
    FIELD_EN     = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  // Low bit of voice v on a 512-bit bus; the slice is [voice_lo(v) +: 16].
  function automatic logic [8:0] voice_lo(input logic [4:0] v);
    return {v, 4'b0000};
  endfunction

endpackage

// File: rtl/osc_amp_ramp.sv
// One voice of the amplitude ramp: steps a signed amplitude toward its target by RAMP_STEP,
// landing exactly on the target instead of overshooting.
module osc_amp_ramp #(
  parameter int unsigned WORD_W = 16,
  parameter logic [WORD_W-1:0] RAMP_STEP = 16'd64
) (
  input  logic signed [WORD_W-1:0] cur,
  input  logic signed [WORD_W-1:0] target,
  output logic signed [WORD_W-1:0] nxt
);

  // One extra bit so target - cur cannot wrap for any pair of 16-bit values.
  logic signed [WORD_W:0] diff;
  logic signed [WORD_W:0] step_x;

  always_comb begin
    diff   = $signed({target[WORD_W-1], target}) - $signed({cur[WORD_W-1], cur});
    step_x = $signed({1'b0, RAMP_STEP});
    nxt    = target;
    if (diff > step_x) begin
      nxt = cur + $signed(RAMP_STEP);
    end else if (diff < -step_x) begin
      nxt = cur - $signed(RAMP_STEP);
    end
  end

endmodule

// File: rtl/osc_bank_config_ctrl.sv
// Shadow/active configuration banks for the 32-voice oscillator bank with frame-aligned commit.
// Optional amplitude ramping toward the committed value is enabled by defining OSC_AMP_RAMP_EN.
module osc_bank_config_ctrl
  import osc_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_voice,
  input  logic [1:0]            wr_field,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  commit_req,
  input  logic                  frame_tick,
  output logic                  commit_ack,
  output logic                  busy,
  output logic [BUS_W-1:0]      amps,
  output logic [BUS_W-1:0]      offsets,
  output logic [BUS_W-1:0]      phasewords,
  output logic [NUM_VOICES-1:0] voice_en
);

  state_e state_q, state_d;
  logic   apply_now;
  logic   wr_accept;

  logic [BUS_W-1:0]      sh_amp, sh_off, sh_ph;
  logic [NUM_VOICES-1:0] sh_en;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    apply_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        busy = 1'b1;
        if (frame_tick) begin
          state_d   = ST_APPLY;
          apply_now = 1'b1;
        end
      end
      ST_APPLY: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_accept = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every register sees pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the banks are reset explicitly: reset must abort a pending commit and zero every voice.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_amp <= '0;
      sh_off <= '0;
      sh_ph  <= '0;
      sh_en  <= '0;
    end else if (wr_accept) begin
      case (field_e'(wr_field))
        FIELD_AMP:    sh_amp[voice_lo(wr_voice) +: WORD_W] <= wr_data;
        FIELD_OFFSET: sh_off[voice_lo(wr_voice) +: WORD_W] <= wr_data;
        FIELD_PHASE:  sh_ph[voice_lo(wr_voice) +: WORD_W]  <= wr_data;
        FIELD_EN:     sh_en[wr_voice]                      <= wr_data[0];
      endcase
    end
  end

  // Active copy lands on the same edge that enters APPLY, so the ack and new values coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      offsets    <= '0;
      phasewords <= '0;
      voice_en   <= '0;
      commit_ack <= 1'b0;
    end else begin
      commit_ack <= apply_now;
      if (apply_now) begin
        offsets    <= sh_off;
        phasewords <= sh_ph;
        voice_en   <= sh_en;
      end
    end
  end

`ifdef OSC_AMP_RAMP_EN
  logic [BUS_W-1:0] amp_target;
  logic [BUS_W-1:0] amp_next;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_ramp
    osc_amp_ramp #(
      .WORD_W    (WORD_W),
      .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
      .cur    (amps[i*WORD_W +: WORD_W]),
      .target (amp_target[i*WORD_W +: WORD_W]),
      .nxt    (amp_next[i*WORD_W +: WORD_W])
    );
  end

  // A tick that triggers APPLY still ramps against the previous target.
  always_ff @(posedge clk) begin
    if (reset) begin
      amp_target <= '0;
      amps       <= '0;
    end else begin
      if (apply_now)  amp_target <= sh_amp;
      if (frame_tick) amps       <= amp_next;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)          amps <= '0;
    else if (apply_now) amps <= sh_amp;
  end
`endif

endmodule

// File: tb/tb_osc_bank_config_ctrl.sv
// Directed self-checking bench for osc_bank_config_ctrl (default build; ramp test under
// OSC_AMP_RAMP_EN).
module tb_osc_bank_config_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_voice;
  logic [1:0]   wr_field;
  logic [15:0]  wr_data;
  logic         commit_req;
  logic         frame_tick;
  logic         commit_ack;
  logic         busy;
  logic [511:0] amps;
  logic [511:0] offsets;
  logic [511:0] phasewords;
  logic [31:0]  voice_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  osc_bank_config_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_voice   (wr_voice),
    .wr_field   (wr_field),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .frame_tick (frame_tick),
    .commit_ack (commit_ack),
    .busy       (busy),
    .amps       (amps),
    .offsets    (offsets),
    .phasewords (phasewords),
    .voice_en   (voice_en)
  );

  // Advance one edge; inputs set before the call are sampled there, outputs read after.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic write(input logic [4:0] v, input logic [1:0] f, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_voice = v;
    wr_field = f;
    wr_data  = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({amps, offsets, phasewords} !== '0) begin
      n_err++; $display("FAIL reset_banks: got nonzero field bus, want all 0");
    end
    n_cmp++;
    if (voice_en !== 32'h0) begin
      n_err++; $display("FAIL reset_voice_en: got %h want 0", voice_en);
    end
    n_cmp++;
    if ({commit_ack, busy, wr_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_ctrl: got ack/busy/ready=%b want 001", {commit_ack, busy, wr_ready});
    end
  endtask

  task automatic test_single_commit();
    int acks;
    logic [511:0] mask;
    logic [15:0] exp_amp;
    acks = 0;
    write(5'd5, 2'd0, 16'h1000);
    pulse_commit();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL t1_busy_pending: got %b want 1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (commit_ack) acks++;
      cycle();
    end
    pulse_tick();
    if (commit_ack) acks++;
    n_cmp++;
    if (commit_ack !== 1'b1) begin
      n_err++; $display("FAIL t1_ack_in_apply: got %b want 1", commit_ack);
    end
`ifdef OSC_AMP_RAMP_EN
    exp_amp = 16'h0000;
`else
    exp_amp = 16'h1000;
`endif
    n_cmp++;
    if (amps[95:80] !== exp_amp) begin
      n_err++; $display("FAIL t1_amp_v5: got %h want %h", amps[95:80], exp_amp);
    end
    mask = '1;
    mask[95:80] = 16'h0;
    n_cmp++;
    if ((amps & mask) !== '0) begin
      n_err++; $display("FAIL t1_other_voices: got nonzero amps outside voice 5, want 0");
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (commit_ack) acks++;
    end
    n_cmp++;
    if (acks !== 1) begin
      n_err++; $display("FAIL t1_ack_count: got %0d want 1", acks);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL t1_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_last_write_wins();
    write(5'd0, 2'd2, 16'h0100);
    write(5'd0, 2'd2, 16'h0200);
    pulse_commit();
    pulse_tick();
    n_cmp++;
    if (phasewords[15:0] !== 16'h0200) begin
      n_err++; $display("FAIL t2_phase_v0: got %h want 0200", phasewords[15:0]);
    end
    cycle();
  endtask

  task automatic test_tick_with_commit();
    commit_req = 1'b1;
    frame_tick = 1'b1;
    cycle();
    commit_req = 1'b0;
    frame_tick = 1'b0;
    n_cmp++;
    if ({busy, commit_ack} !== 2'b10) begin
      n_err++; $display("FAIL t3_pending_after_tick: got busy/ack=%b want 10", {busy, commit_ack});
    end
    wr_valid = 1'b1;
    wr_voice = 5'd7;
    wr_field = 2'd1;
    wr_data  = 16'hBEEF;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++; $display("FAIL t3_ready_pending: got %b want 0", wr_ready);
    end
    cycle();
    wr_valid = 1'b0;
    cycle();
    n_cmp++;
    if ({busy, commit_ack} !== 2'b10) begin
      n_err++; $display("FAIL t3_still_pending: got busy/ack=%b want 10", {busy, commit_ack});
    end
    pulse_tick();
    n_cmp++;
    if (commit_ack !== 1'b1) begin
      n_err++; $display("FAIL t3_ack_second_tick: got %b want 1", commit_ack);
    end
    n_cmp++;
    if (offsets[127:112] !== 16'h0000) begin
      n_err++; $display("FAIL t3_write_rejected: got %h want 0000", offsets[127:112]);
    end
    cycle();
  endtask

  task automatic test_reset_abort();
    int acks;
    acks = 0;
    write(5'd3, 2'd3, 16'h0001);
    pulse_commit();
    reset      = 1'b1;
    frame_tick = 1'b1;
    cycle();
    reset      = 1'b0;
    frame_tick = 1'b0;
    if (commit_ack) acks++;
    n_cmp++;
    if ({amps, offsets, phasewords} !== '0) begin
      n_err++; $display("FAIL t4_banks_cleared: got nonzero field bus, want all 0");
    end
    n_cmp++;
    if (voice_en !== 32'h0) begin
      n_err++; $display("FAIL t4_voice_en: got %h want 0", voice_en);
    end
    n_cmp++;
    if ({busy, wr_ready} !== 2'b01) begin
      n_err++; $display("FAIL t4_idle_after_reset: got busy/ready=%b want 01", {busy, wr_ready});
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      if (commit_ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++; $display("FAIL t4_no_ack: got %0d acks want 0", acks);
    end
  endtask

  task automatic test_same_cycle_write_commit();
    wr_valid   = 1'b1;
    wr_voice   = 5'd31;
    wr_field   = 2'd3;
    wr_data    = 16'h0001;
    commit_req = 1'b1;
    cycle();
    wr_valid   = 1'b0;
    commit_req = 1'b0;
    pulse_tick();
    n_cmp++;
    if (voice_en !== 32'h8000_0000) begin
      n_err++; $display("FAIL t5_voice_en31: got %h want 80000000", voice_en);
    end
    cycle();
  endtask

`ifdef OSC_AMP_RAMP_EN
  task automatic test_ramp();
    logic [15:0] up [4];
    logic [15:0] dn [6];
    up = '{16'd64, 16'd128, 16'd192, 16'd200};
    dn = '{16'd136, 16'd72, 16'd8, 16'hFFC8, 16'hFF9C, 16'hFF9C};
    do_reset();
    write(5'd2, 2'd0, 16'd200);
    pulse_commit();
    pulse_tick();
    n_cmp++;
    if (amps[47:32] !== 16'd0) begin
      n_err++; $display("FAIL t6_apply_no_jump: got %h want 0000", amps[47:32]);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      n_cmp++;
      if (amps[47:32] !== up[i]) begin
        n_err++; $display("FAIL t6_ramp_up[%0d]: got %h want %h", i, amps[47:32], up[i]);
      end
    end
    write(5'd2, 2'd0, 16'hFF9C);
    pulse_commit();
    pulse_tick();
    n_cmp++;
    if (amps[47:32] !== 16'd200) begin
      n_err++; $display("FAIL t6_hold_at_apply: got %h want 00c8", amps[47:32]);
    end
    for (int i = 0; i < 6; i++) begin
      pulse_tick();
      n_cmp++;
      if (amps[47:32] !== dn[i]) begin
        n_err++; $display("FAIL t6_ramp_down[%0d]: got %h want %h", i, amps[47:32], dn[i]);
      end
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    wr_valid   = 1'b0;
    wr_voice   = 5'd0;
    wr_field   = 2'd0;
    wr_data    = 16'h0;
    commit_req = 1'b0;
    frame_tick = 1'b0;
    test_reset();
    test_single_commit();
    test_last_write_wins();
    test_tick_with_commit();
    test_reset_abort();
    test_same_cycle_write_commit();
`ifdef OSC_AMP_RAMP_EN
    test_ramp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
